pixel_scan_sequencer: RTL

- Frame-level scan controller directly upstream of chip_driver; it produces that block's i_write_key/i_write_col/i_write_row/i_data_col/i_data_row commands and consumes its o_rdy.
- Walks a one-hot token through the sensor's row and column shift registers and visits every pixel in raster order.
- At each pixel it issues a key write, then a sample request to the ADC capture path, and waits for the capture to be acknowledged.

---
 rtl/pixel_scan_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_scan_sequencer.sv
// Frame scan controller: walks a one-hot token through the row/column shift registers and
// issues key writes and sample requests to every pixel. Optional watchdog: SCAN_TIMEOUT_EN.
module pixel_scan_sequencer #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_n_cols,
  input  logic [CNT_W-1:0] i_n_rows,
  input  logic             i_drv_rdy,
  input  logic             i_smp_ack,
  output logic             o_write_key,
  output logic             o_write_col,
  output logic             o_write_row,
  output logic             o_data_col,
  output logic             o_data_row,
  output logic             o_smp_req,
  output logic [CNT_W-1:0] o_col_idx,
  output logic [CNT_W-1:0] o_row_idx,
  output logic             o_busy,
`ifdef SCAN_TIMEOUT_EN
  output logic             o_timeout,
`endif
  output logic             o_frame_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ROW_INJ   = 3'd1;
  localparam logic [2:0] S_COL_INJ   = 3'd2;
  localparam logic [2:0] S_KEY       = 3'd3;
  localparam logic [2:0] S_SMP       = 3'd4;
  localparam logic [2:0] S_COL_SHIFT = 3'd5;
  localparam logic [2:0] S_ROW_SHIFT = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [1:0] HS_ISSUE   = 2'd0;
  localparam logic [1:0] HS_WAIT_LO = 2'd1;
  localparam logic [1:0] HS_WAIT_HI = 2'd2;

  logic [2:0]       st_q, st_d;
  logic [1:0]       hs_q, hs_d;
  logic [CNT_W-1:0] ncol_q, ncol_d, nrow_q, nrow_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             abort_q, abort_d;
  logic             busy, cmd_state, abort_now, last_col, last_row;

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_q, tmo_d;
  logic          waiting;
`endif

  assign busy      = (st_q != S_IDLE) && (st_q != S_DONE);
  assign cmd_state = (st_q == S_ROW_INJ) || (st_q == S_COL_INJ) || (st_q == S_KEY) ||
                     (st_q == S_COL_SHIFT) || (st_q == S_ROW_SHIFT);
  assign abort_now = abort_q || (i_abort && busy);
  assign last_col  = (col_q == ncol_q - CNT_W'(1));
  assign last_row  = (row_q == nrow_q - CNT_W'(1));

  always_comb begin
    st_d    = st_q;
    hs_d    = hs_q;
    ncol_d  = ncol_q;
    nrow_d  = nrow_q;
    col_d   = col_q;
    row_d   = row_q;
    abort_d = busy ? abort_now : 1'b0;
`ifdef SCAN_TIMEOUT_EN
    tmo_d   = tmo_q;
    tcnt_d  = '0;
    waiting = (cmd_state && (hs_q != HS_ISSUE)) || (st_q == S_SMP);
`endif
    case (st_q)
      S_IDLE: begin
        // An abort arriving with the accepted start is dropped on purpose.
        if (i_start && (i_n_cols != '0) && (i_n_rows != '0)) begin
          st_d    = S_ROW_INJ;
          hs_d    = HS_ISSUE;
          ncol_d  = i_n_cols;
          nrow_d  = i_n_rows;
          col_d   = '0;
          row_d   = '0;
          abort_d = 1'b0;
`ifdef SCAN_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_DONE: st_d = S_IDLE;
      S_SMP: begin
        if (i_smp_ack) begin
          hs_d = HS_ISSUE;
          if (abort_now)     st_d = S_DONE;
          else if (!last_col) st_d = S_COL_SHIFT;
          else if (!last_row) st_d = S_ROW_SHIFT;
          else               st_d = S_DONE;
        end
      end
      default: begin
        // Requiring ready to fall before it rises stops a stale ready completing a command.
        case (hs_q)
          HS_ISSUE:   hs_d = HS_WAIT_LO;
          HS_WAIT_LO: if (!i_drv_rdy) hs_d = HS_WAIT_HI;
          default: begin
            if (i_drv_rdy) begin
              hs_d = HS_ISSUE;
              case (st_q)
                S_ROW_INJ: st_d = S_COL_INJ;
                S_COL_INJ: st_d = S_KEY;
                S_KEY:     st_d = S_SMP;
                S_COL_SHIFT: begin
                  st_d  = S_KEY;
                  col_d = col_q + CNT_W'(1);
                end
                default: begin
                  st_d  = S_COL_INJ;
                  row_d = row_q + CNT_W'(1);
                  col_d = '0;
                end
              endcase
              if (abort_now) st_d = S_DONE;
            end
          end
        endcase
      end
    endcase
`ifdef SCAN_TIMEOUT_EN
    if (waiting && (tcnt_q == TW'(TIMEOUT_CYC - 1))) begin
      st_d  = S_DONE;
      hs_d  = HS_ISSUE;
      tmo_d = 1'b1;
    end
    if (waiting && (st_d == st_q) && (hs_d == hs_q)) tcnt_d = tcnt_q + TW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S_IDLE;
      hs_q    <= HS_ISSUE;
      ncol_q  <= '0;
      nrow_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      abort_q <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      hs_q    <= hs_d;
      ncol_q  <= ncol_d;
      nrow_q  <= nrow_d;
      col_q   <= col_d;
      row_q   <= row_d;
      abort_q <= abort_d;
`ifdef SCAN_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Strobes and their data exist only in the ISSUE cycle of a command.
  assign o_write_row  = ((st_q == S_ROW_INJ) || (st_q == S_ROW_SHIFT)) && (hs_q == HS_ISSUE);
  assign o_data_row   = (st_q == S_ROW_INJ) && (hs_q == HS_ISSUE);
  assign o_write_col  = ((st_q == S_COL_INJ) || (st_q == S_COL_SHIFT)) && (hs_q == HS_ISSUE);
  assign o_data_col   = (st_q == S_COL_INJ) && (hs_q == HS_ISSUE);
  assign o_write_key  = (st_q == S_KEY) && (hs_q == HS_ISSUE);
  assign o_smp_req    = (st_q == S_SMP);
  assign o_col_idx    = col_q;
  assign o_row_idx    = row_q;
  assign o_busy       = busy;
  assign o_frame_done = (st_q == S_DONE);
`ifdef SCAN_TIMEOUT_EN
  assign o_timeout    = tmo_q;
`endif

endmodule
